// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (1-cycle read latency) into a
// valid/ready stream with fixed-length packet framing. A 3-entry skid buffer
// absorbs the read latency, so reads never depend combinationally on m_ready.
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] pkt_count,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic              inflight_reg;
    logic [1:0]        head_reg;
    logic [1:0]        tail_reg;
    logic [BEAT_W-1:0] beat_idx_reg;
    logic [CNT_W-1:0]  pkt_count_reg;
    logic [WIDTH-1:0]  mem_reg [0:2];

    logic has_room;
    logic capture;
    logic handshake;

    // Circular pointer increment over the three buffer slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read request and stream handshake decode; only registered occupancy is
    // used for the room test so m_ready stays out of the rd_en path.
    always_comb begin
        has_room   = ({1'b0, occ_reg} + {2'b00, inflight_reg}) < 3'd3;
        fifo_rd_en = !reset && (state_reg == RUN) && enable && !flush
                     && !fifo_empty && has_room;
        capture    = inflight_reg && !flush;
        m_valid    = (occ_reg != 2'd0);
        m_data     = mem_reg[head_reg];
        m_last     = m_valid && (beat_idx_reg == BEAT_LAST);
        handshake  = m_valid && m_ready;
        busy       = (state_reg != IDLE);
        pkt_count  = pkt_count_reg;
    end

    // Occupancy: a capture and a pop in the same cycle cancel out.
    always_comb begin
        occ_next = occ_reg;
        case ({inflight_reg, handshake})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    // Run/stop/idle sequencing; STOP waits for the buffer and pipeline to empty.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (enable) state_next = RUN;
            RUN:  if (!enable) state_next = STOP;
            STOP: begin
                if (enable)
                    state_next = RUN;
                else if ((occ_reg == 2'd0) && !inflight_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: flush clears everything buffered or in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            occ_reg       <= 2'd0;
            inflight_reg  <= 1'b0;
            head_reg      <= 2'd0;
            tail_reg      <= 2'd0;
            beat_idx_reg  <= '0;
            pkt_count_reg <= '0;
        end else if (flush) begin
            state_reg     <= IDLE;
            occ_reg       <= 2'd0;
            inflight_reg  <= 1'b0;
            head_reg      <= 2'd0;
            tail_reg      <= 2'd0;
            beat_idx_reg  <= '0;
            pkt_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd_en;
            if (inflight_reg)
                tail_reg <= ptr_inc(tail_reg);
            if (handshake) begin
                head_reg <= ptr_inc(head_reg);
                if (beat_idx_reg == BEAT_LAST) begin
                    beat_idx_reg  <= '0;
                    pkt_count_reg <= pkt_count_reg + 1'b1;
                end else begin
                    beat_idx_reg <= beat_idx_reg + 1'b1;
                end
            end
        end
    end

    // Skid buffer slots: each slot loads FIFO data when the tail points at it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    mem_reg[gi] <= '0;
                else if (capture && (tail_reg == 2'(gi)))
                    mem_reg[gi] <= fifo_rdata;
            end
        end
    endgenerate

endmodule
